// File: rtl/d_tile_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : d_tile_loader_pkg
// Description : Shared defaults and the loader state encoding for the D tile
//               loader and its row shift registers.
// Revision    : 1.0 - initial release
// ============================================================================
package d_tile_loader_pkg;

  localparam int c_def_n1  = 4;  // rows per tile
  localparam int c_def_n2  = 4;  // words per row
  localparam int c_def_d_w = 8;  // data word width

  // FILL: collecting words; FULL: tile presented, waiting for handshake
  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage : d_tile_loader_pkg
`default_nettype wire

// File: rtl/d_row_shreg.sv
`default_nettype none
// ============================================================================
// Module      : d_row_shreg
// Description : One tile row: N2-deep word shift register plus a count of
//               words captured since the last clear.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               clr        - clear counter (tile handed off)
//               shift      - capture din into element 0, shift the rest up
//               din        - incoming word
//               row        - element k at bits [k*D_W +: D_W]
//               cnt        - captured-word counter (0..N2)
// Revision    : 1.0 - initial release
// ============================================================================
module d_row_shreg
  import d_tile_loader_pkg::*;
#(
  parameter int N2  = c_def_n2,
  parameter int D_W = c_def_d_w,
  parameter int CW  = $clog2(N2 + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift,
  input  logic [D_W-1:0]    din,
  output logic [N2*D_W-1:0] row,
  output logic [CW-1:0]     cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      cnt <= '0;
    end else begin
      if (shift) begin
        for (int k = N2 - 1; k > 0; k--) begin
          row[k*D_W +: D_W] <= row[(k-1)*D_W +: D_W];
        end
        row[D_W-1:0] <= din;
      end
      // A word captured in the handoff cycle is the first of the next tile
      if (clr) begin
        cnt <= shift ? CW'(1) : '0;
      end else if (shift) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule : d_row_shreg
`default_nettype wire

// File: rtl/d_tile_loader.sv
`default_nettype none
// ============================================================================
// Module      : d_tile_loader
// Description : Assembles N1 x N2 word tiles from memory read data steered by
//               a one-hot row select, and hands each complete tile to the
//               systolic array with a valid/ready handshake.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               activate_D [N1]     - one-hot row select, aligned with address
//               rd_data_D  [D_W]    - read data, MEM_LAT cycles after address
//               tile_valid / ready  - tile handshake
//               tile_data           - row r elem k at [(r*N2+k)*D_W +: D_W]
//               tile_count [16]     - tiles handed off (wrapping)
//               overflow            - sticky: a word was dropped
//               onehot_err          - sticky: multi-hot select seen
// Config      : D_TILE_ONEHOT_CHECK_EN - when defined, multi-hot selects are
//               dropped and flagged; otherwise the lowest set bit wins and
//               onehot_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module d_tile_loader
  import d_tile_loader_pkg::*;
#(
  parameter int N1      = c_def_n1,
  parameter int N2      = c_def_n2,
  parameter int D_W     = c_def_d_w,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N1-1:0]        activate_D,
  input  logic [D_W-1:0]       rd_data_D,
  output logic                 tile_valid,
  input  logic                 tile_ready,
  output logic [N1*N2*D_W-1:0] tile_data,
  output logic [15:0]          tile_count,
  output logic                 overflow,
  output logic                 onehot_err
);

  localparam int            CW         = $clog2(N2 + 1);
  localparam logic [CW-1:0] c_cnt_full = CW'(N2);
  localparam logic [CW-1:0] c_cnt_last = CW'(N2 - 1);

  logic [N1-1:0] r_act_dly [MEM_LAT];
  logic [N1-1:0] w_act;
  logic [N1-1:0] w_sel;
  logic [N1-1:0] w_cap;
  logic [N1-1:0] w_full_nxt;
  logic [CW-1:0] w_cnt [N1];
  logic          w_hs;
  logic          w_ovf_drop;
  state_t        r_state;

  // Row select delayed to line up with the returning read data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) r_act_dly[i] <= '0;
    end else begin
      r_act_dly[0] <= activate_D;
      for (int i = 1; i < MEM_LAT; i++) r_act_dly[i] <= r_act_dly[i-1];
    end
  end

  assign w_act = r_act_dly[MEM_LAT-1];
  assign w_hs  = (r_state == ST_FULL) && tile_ready;

`ifdef D_TILE_ONEHOT_CHECK_EN
  logic w_multi;
  assign w_multi = |(w_act & (w_act - N1'(1)));
  assign w_sel   = w_multi ? '0 : w_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      onehot_err <= 1'b0;
    end else if (w_multi) begin
      onehot_err <= 1'b1;
    end
  end
`else
  // Isolate the lowest set bit so a multi-hot select still picks one row
  assign w_sel      = w_act & ((~w_act) + N1'(1));
  assign onehot_err = 1'b0;
`endif

  // A routed word that no row takes is an overflow
  assign w_ovf_drop = (|w_sel) && !(|w_cap);

  for (genvar r = 0; r < N1; r++) begin : g_row
    // In FULL a word is only accepted when the tile leaves in the same cycle
    assign w_cap[r] = w_sel[r] &&
                      ((r_state == ST_FILL) ? (w_cnt[r] != c_cnt_full) : w_hs);

    // Row will hold N2 words after this edge
    assign w_full_nxt[r] = w_hs ? (w_cap[r] && (N2 == 1))
                                : ((w_cnt[r] == c_cnt_full) ||
                                   (w_cap[r] && (w_cnt[r] == c_cnt_last)));

    d_row_shreg #(
      .N2  (N2),
      .D_W (D_W),
      .CW  (CW)
    ) u_row (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_hs),
      .shift (w_cap[r]),
      .din   (rd_data_D),
      .row   (tile_data[r*N2*D_W +: N2*D_W]),
      .cnt   (w_cnt[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FILL;
      tile_valid <= 1'b0;
      tile_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (w_ovf_drop) overflow <= 1'b1;
      case (r_state)
        ST_FILL: begin
          if (&w_full_nxt) begin
            r_state    <= ST_FULL;
            tile_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (tile_ready) begin
            tile_count <= tile_count + 16'd1;
            if (!(&w_full_nxt)) begin
              r_state    <= ST_FILL;
              tile_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= ST_FILL;
          tile_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : d_tile_loader
`default_nettype wire

// File: tb/tb_d_tile_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_tile_loader
// Description : Directed testbench for d_tile_loader (N1=2, N2=2, D_W=8,
//               MEM_LAT=1) with a queue-based reference model and literal
//               checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_d_tile_loader;

  localparam int N1  = 2;
  localparam int N2  = 2;
  localparam int D_W = 8;
  localparam int TW  = N1 * N2 * D_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N1-1:0] activate_D = '0;
  logic [D_W-1:0] rd_data_D = '0;
  logic          tile_ready = 1'b0;
  logic          tile_valid;
  logic [TW-1:0] tile_data;
  logic [15:0]   tile_count;
  logic          overflow;
  logic          onehot_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  d_tile_loader #(
    .N1      (N1),
    .N2      (N2),
    .D_W     (D_W),
    .MEM_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .activate_D (activate_D),
    .rd_data_D  (rd_data_D),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .tile_count (tile_count),
    .overflow   (overflow),
    .onehot_err (onehot_err)
  );

  // ---------------- reference model ----------------
  // Each row keeps its captured words newest-first; element k is the k-th
  // most recent word captured into that row.
  logic [D_W-1:0] m_q [N1][$];
  int            m_cnt [N1];
  logic [N1-1:0] m_pend = '0;
  logic          m_valid = 1'b0;
  logic [15:0]   m_count = '0;
  logic          m_ovf = 1'b0;
  logic          m_ohe = 1'b0;
  int            m_row;
  logic          m_hs;
  logic          m_all;

  always @(posedge clk) begin
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_count = '0;
      m_ovf   = 1'b0;
      m_ohe   = 1'b0;
      for (int r = 0; r < N1; r++) begin
        m_q[r].delete();
        m_cnt[r] = 0;
      end
    end else begin
      m_hs = m_valid && tile_ready;
      if (m_hs) begin
        m_count = m_count + 16'd1;
        for (int r = 0; r < N1; r++) m_cnt[r] = 0;
      end
      m_row = -1;
      for (int r = N1 - 1; r >= 0; r--) if (m_pend[r]) m_row = r;
`ifdef D_TILE_ONEHOT_CHECK_EN
      if ($countones(m_pend) > 1) begin
        m_row = -1;
        m_ohe = 1'b1;
      end
`endif
      if (m_row >= 0) begin
        if (m_hs || (!m_valid && m_cnt[m_row] < N2)) begin
          m_q[m_row].push_front(rd_data_D);
          if (m_q[m_row].size() > N2) void'(m_q[m_row].pop_back());
          m_cnt[m_row]++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_all = 1'b1;
      for (int r = 0; r < N1; r++) if (m_cnt[r] != N2) m_all = 1'b0;
      m_valid = m_all;
      m_pend  = activate_D;
    end
  end

  function automatic logic [TW-1:0] model_data();
    logic [TW-1:0] v;
    v = '0;
    for (int r = 0; r < N1; r++)
      for (int k = 0; k < N2; k++)
        if (k < m_q[r].size()) v[(r*N2+k)*D_W +: D_W] = m_q[r][k];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model tile_valid", 64'(tile_valid), 64'(m_valid));
      check("model tile_data",  64'(tile_data),  64'(model_data()));
      check("model tile_count", 64'(tile_count), 64'(m_count));
      check("model overflow",   64'(overflow),   64'(m_ovf));
      check("model onehot_err", 64'(onehot_err), 64'(m_ohe));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input logic [N1-1:0] act, input logic [D_W-1:0] d, input logic rdy);
    activate_D = act;
    rd_data_D  = d;
    tile_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, " valid"}, 64'(tile_valid), 64'd0);
    check({tag, " data"},  64'(tile_data),  64'd0);
    check({tag, " count"}, 64'(tile_count), 64'd0);
    check({tag, " ovf"},   64'(overflow),   64'd0);
    check({tag, " ohe"},   64'(onehot_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    tick(2'b00, 8'h00, 1'b0);
    tick(2'b00, 8'h00, 1'b0);
    cmp_en = 1'b1;
    rst = 1'b0;
    chk_zero("reset");

    // Basic fill: A=11 B=22 C=33 D=44
    tick(2'b01, 8'h00, 1'b0);
    tick(2'b01, 8'h11, 1'b0);
    tick(2'b10, 8'h22, 1'b0);
    tick(2'b10, 8'h33, 1'b0);
    check("fill not yet valid", 64'(tile_valid), 64'd0);
    tick(2'b00, 8'h44, 1'b0);
    check("fill valid", 64'(tile_valid), 64'd1);
    check("fill data",  64'(tile_data),  64'h33441122);

    // Backpressure; last held cycle issues a row0 read for the handoff cycle
    tick(2'b00, 8'h00, 1'b0);
    check("bp hold data 1", 64'(tile_data), 64'h33441122);
    tick(2'b00, 8'h00, 1'b0);
    check("bp hold data 2", 64'(tile_data), 64'h33441122);
    tick(2'b01, 8'h00, 1'b0);
    check("bp hold data 3", 64'(tile_data), 64'h33441122);
    check("bp hold valid",  64'(tile_valid), 64'd1);

    // Handshake with 5A arriving for row0 in the same cycle
    tick(2'b00, 8'h5A, 1'b1);
    check("hs valid low", 64'(tile_valid), 64'd0);
    check("hs count",     64'(tile_count), 64'd1);
    check("hs ovf",       64'(overflow),   64'd0);
    check("hs capture",   64'(tile_data),  64'h3344225A);

    // Row0 needs one more word, row1 two
    tick(2'b01, 8'h00, 1'b0);
    tick(2'b10, 8'h61, 1'b0);
    tick(2'b10, 8'h62, 1'b0);
    check("2nd not yet valid", 64'(tile_valid), 64'd0);
    tick(2'b00, 8'h63, 1'b0);
    check("2nd valid", 64'(tile_valid), 64'd1);
    check("2nd data",  64'(tile_data),  64'h62635A61);

    // Overflow: word arrives in FULL without ready
    tick(2'b01, 8'h00, 1'b0);
    tick(2'b00, 8'h99, 1'b0);
    check("ovf set",       64'(overflow),  64'd1);
    check("ovf data kept", 64'(tile_data), 64'h62635A61);
    tick(2'b00, 8'h00, 1'b1);
    check("ovf count", 64'(tile_count), 64'd2);
    tick(2'b00, 8'h00, 1'b0);
    tick(2'b00, 8'h00, 1'b0);
    check("ovf sticky", 64'(overflow), 64'd1);

    rst = 1'b1;
    tick(2'b00, 8'h00, 1'b0);
    rst = 1'b0;
    chk_zero("reset2");

    // Multi-hot select
    tick(2'b11, 8'h00, 1'b0);
    tick(2'b00, 8'hC3, 1'b0);
`ifdef D_TILE_ONEHOT_CHECK_EN
    check("multihot data", 64'(tile_data),  64'h0);
    check("multihot ohe",  64'(onehot_err), 64'd1);
`else
    check("multihot data", 64'(tile_data),  64'hC3);
    check("multihot ohe",  64'(onehot_err), 64'd0);
`endif

    // Reset mid-fill, with a select asserted during reset
    tick(2'b01, 8'h00, 1'b0);
    tick(2'b10, 8'hD1, 1'b0);
    tick(2'b01, 8'hD2, 1'b0);
    rst = 1'b1;
    tick(2'b01, 8'hD3, 1'b1);
    rst = 1'b0;
    chk_zero("reset3");
    tick(2'b01, 8'h00, 1'b0);
    tick(2'b01, 8'hE1, 1'b0);
    tick(2'b10, 8'hE2, 1'b0);
    tick(2'b10, 8'hE3, 1'b0);
    check("post-rst 3 words", 64'(tile_valid), 64'd0);
    tick(2'b00, 8'hE4, 1'b0);
    check("post-rst valid", 64'(tile_valid), 64'd1);
    check("post-rst data",  64'(tile_data),  64'hE3E4E1E2);

    tick(2'b00, 8'h00, 1'b1);
    tick(2'b00, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_d_tile_loader
`default_nettype wire
